// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC source encodings and default PC parameters.
// Imported by the program-counter unit and its return stack.
package cpu_pkg;

  typedef enum logic [1:0] {
    PC_SRC_SEQ = 2'd0,
    PC_SRC_BR  = 2'd1,
    PC_SRC_JMP = 2'd2,
    PC_SRC_RET = 2'd3
  } pc_src_e;

  localparam int          PC_WIDTH_DEF = 32;
  localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with push, pop and top-replace.
// A push into a full stack silently overwrites the oldest entry.
module ras_stack
  import cpu_pkg::*;
#(
  parameter int               WIDTH        = PC_WIDTH_DEF,
  parameter int               DEPTH        = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VEC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_top,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_top;
  logic [CW-1:0]    r_count;

  logic          w_empty;
  logic          w_full;
  logic          w_grow;
  logic          w_repl;
  logic          w_drop;
  logic [PW-1:0] w_top_inc;
  logic [PW-1:0] w_top_dec;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_top_inc = r_top + 1'b1;
  assign w_top_dec = r_top - 1'b1;

  // A combined push/pop on an empty stack has nothing to replace, so it grows.
  assign w_grow = i_push & (~i_pop | w_empty);
  assign w_repl = i_push & i_pop & ~w_empty;
  assign w_drop = i_pop & ~i_push & ~w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (w_grow) begin
      r_top <= w_top_inc;
      if (!w_full) r_count <= r_count + 1'b1;
    end else if (w_drop) begin
      r_top   <= w_top_dec;
      r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_grow)      r_mem[w_top_inc] <= i_wdata;
      else if (w_repl) r_mem[r_top]     <= i_wdata;
    end
  end

  assign o_top   = w_empty ? RESET_VECTOR : r_mem[r_top];
  assign o_empty = w_empty;
  assign o_full  = w_full;

endmodule

// File: rtl/pc_unit.sv
// Program counter with internal next-PC mux, write qualification,
// and a return-address stack with sticky overflow/underflow status.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int               WIDTH        = PC_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VEC),
  parameter int               INCR         = 4,
  parameter int               ALIGN_SHIFT  = 2,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_write,
  input  logic             pc_write_cond,
  input  logic             cond_true,
  input  logic [1:0]       src_sel,
  input  logic [WIDTH-1:0] branch_off,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             ras_underflow,
  output logic             misalign
);

  localparam logic [WIDTH-1:0] ALIGN_MASK =
    WIDTH'((64'd1 << ALIGN_SHIFT) - 64'd1);

  logic [WIDTH-1:0] r_pc;
  logic             r_ovf;
  logic             r_unf;
  logic             r_mis;

  logic             w_upd;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] w_ras_top;
  logic             w_ras_empty;
  logic             w_ras_full;
  logic             w_mis_nxt;

  assign w_upd    = pc_write | (pc_write_cond & cond_true);
  assign w_push   = w_upd & push;
  assign w_pop    = w_upd & pop;
  assign w_pc_inc = r_pc + WIDTH'(INCR);

  always_comb begin
    w_pc_nxt  = w_pc_inc;
    w_mis_nxt = 1'b0;
    unique case (pc_src_e'(src_sel))
      PC_SRC_SEQ: w_pc_nxt = w_pc_inc;
      PC_SRC_BR:  w_pc_nxt = w_pc_inc + (branch_off << ALIGN_SHIFT);
      PC_SRC_JMP: begin
        w_pc_nxt  = jump_target & ~ALIGN_MASK;
        w_mis_nxt = |(jump_target & ALIGN_MASK);
      end
      PC_SRC_RET: w_pc_nxt = w_ras_top;
      default:    w_pc_nxt = w_pc_inc;
    endcase
  end

  ras_stack #(
    .WIDTH       (WIDTH),
    .DEPTH       (RAS_DEPTH),
    .RESET_VECTOR(RESET_VECTOR)
  ) u_ras (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_wdata(w_pc_inc),
    .o_top  (w_ras_top),
    .o_empty(w_ras_empty),
    .o_full (w_ras_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc  <= RESET_VECTOR;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      r_mis <= 1'b0;
    end else begin
      r_mis <= w_upd & w_mis_nxt;
      if (w_upd) r_pc <= w_pc_nxt;
      if (w_push & ~w_pop & w_ras_full) r_ovf <= 1'b1;
      if (w_pop & w_ras_empty) r_unf <= 1'b1;
    end
  end

  assign pc            = r_pc;
  assign ras_top       = w_ras_top;
  assign ras_empty     = w_ras_empty;
  assign ras_full      = w_ras_full;
  assign ras_overflow  = r_ovf;
  assign ras_underflow = r_unf;
  assign misalign      = r_mis;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed plan plus random traffic against a
// queue-based reference model; also an 8-bit instance for wrap-around.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst, pw, pwc, cond, push, pop;
  logic [1:0]  sel;
  logic [31:0] off, tgt;
  logic [31:0] pc, top;
  logic        emp, full, ovf, unf, mis;

  logic        rst8, pw8;
  logic [7:0]  tgt8, pc8, top8;
  logic        emp8, full8, ovf8, unf8, mis8;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic        m_ovf, m_unf, m_mis;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .rst(rst), .pc_write(pw), .pc_write_cond(pwc),
    .cond_true(cond), .src_sel(sel), .branch_off(off),
    .jump_target(tgt), .push(push), .pop(pop), .pc(pc),
    .ras_top(top), .ras_empty(emp), .ras_full(full),
    .ras_overflow(ovf), .ras_underflow(unf), .misalign(mis)
  );

  pc_unit #(.WIDTH(8), .RESET_VECTOR(8'h00)) dut8 (
    .clk(clk), .rst(rst8), .pc_write(pw8), .pc_write_cond(1'b0),
    .cond_true(1'b0), .src_sel(sel), .branch_off(8'h00),
    .jump_target(tgt8), .push(1'b0), .pop(1'b0), .pc(pc8),
    .ras_top(top8), .ras_empty(emp8), .ras_full(full8),
    .ras_overflow(ovf8), .ras_underflow(unf8), .misalign(mis8)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_top();
    return (m_q.size() == 0) ? 32'h0 : m_q[m_q.size()-1];
  endfunction

  task automatic model_edge();
    logic [31:0] nxt;
    if (rst) begin
      m_pc = 0; m_q.delete(); m_ovf = 0; m_unf = 0; m_mis = 0;
      return;
    end
    if (!(pw || (pwc && cond))) begin
      m_mis = 0;
      return;
    end
    case (sel)
      2'd0: nxt = m_pc + 4;
      2'd1: nxt = m_pc + 4 + off * 4;
      2'd2: nxt = {tgt[31:2], 2'b00};
      default: nxt = m_top();
    endcase
    m_mis = (sel == 2'd2) && (tgt[1:0] != 0);
    if (push && !pop) begin
      if (m_q.size() == 4) begin
        void'(m_q.pop_front());
        m_ovf = 1;
      end
      m_q.push_back(m_pc + 4);
    end else if (pop && !push) begin
      if (m_q.size() > 0) void'(m_q.pop_back());
      else m_unf = 1;
    end else if (push && pop) begin
      if (m_q.size() == 0) begin
        m_q.push_back(m_pc + 4);
        m_unf = 1;
      end else m_q[m_q.size()-1] = m_pc + 4;
    end
    m_pc = nxt;
  endtask

  task automatic compare_all();
    check("pc", pc, m_pc);
    check("ras_top", top, m_top());
    check("ras_empty", 32'(emp), 32'(m_q.size() == 0));
    check("ras_full", 32'(full), 32'(m_q.size() == 4));
    check("ras_overflow", 32'(ovf), 32'(m_ovf));
    check("ras_underflow", 32'(unf), 32'(m_unf));
    check("misalign", 32'(mis), 32'(m_mis));
  endtask

  task automatic step(logic r, logic w, logic wc, logic c, logic [1:0] s,
                      logic [31:0] o, logic [31:0] t, logic pu, logic po);
    rst = r; pw = w; pwc = wc; cond = c; sel = s;
    off = o; tgt = t; push = pu; pop = po;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1; pw = 0; pwc = 0; cond = 0; sel = 0;
    off = 0; tgt = 0; push = 0; pop = 0;
    rst8 = 1; pw8 = 0; tgt8 = 0;
    m_pc = 0; m_ovf = 0; m_unf = 0; m_mis = 0;

    // reset and sequential
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("reset_pc", pc, 32'h0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("seq_pc", pc, 32'hC);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("hold_pc", pc, 32'hC);

    // conditional branch from 0x10
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, -32'sd2, 0, 0, 0);
    check("br_not_taken", pc, 32'h10);
    step(0, 0, 1, 1, 1, -32'sd2, 0, 0, 0);
    check("br_taken", pc, 32'hC);

    // call with misaligned target, then return
    step(0, 1, 0, 0, 2, 0, 32'h20, 0, 0);
    step(0, 1, 0, 0, 2, 0, 32'h103, 1, 0);
    check("call_pc", pc, 32'h100);
    check("call_mis", 32'(mis), 1);
    check("call_top", top, 32'h24);
    step(0, 1, 0, 0, 3, 0, 0, 0, 1);
    check("ret_pc", pc, 32'h24);
    check("ret_mis_clear", 32'(mis), 0);
    check("ret_empty", 32'(emp), 1);

    // five calls overflow a 4-deep stack, five returns underflow it
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++)
      step(0, 1, 0, 0, 2, 0, 32'(i * 'h40), 1, 0);
    check("ovf_flag", 32'(ovf), 1);
    check("ovf_full", 32'(full), 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 3, 0, 0, 0, 1);
      check("ret_chain", pc, 32'h104 - 32'(i * 'h40));
    end
    step(0, 1, 0, 0, 3, 0, 0, 0, 1);
    check("unf_flag", 32'(unf), 1);
    check("unf_pc", pc, 32'h0);

    // reset with a push pending on a 2-entry stack
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 2, 0, 32'h80, 1, 0);
    step(0, 1, 0, 0, 2, 0, 32'h200, 1, 0);
    step(1, 1, 0, 0, 2, 0, 32'h301, 1, 0);
    check("rst_pc", pc, 32'h0);
    check("rst_empty", 32'(emp), 1);
    check("rst_flags", {29'd0, ovf, unf, mis}, 0);

    // 8-bit wrap
    @(negedge clk); rst8 = 0; pw8 = 1; sel = 2; tgt8 = 8'hFC;
    @(negedge clk); sel = 0;
    check("w8_fc", 32'(pc8), 32'hFC);
    @(negedge clk); pw8 = 0;
    check("w8_wrap", 32'(pc8), 32'h0);
    check("w8_flags", {29'd0, ovf8, unf8, mis8}, 0);
    check("w8_empty", 32'(emp8), 1);

    // random traffic
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 60) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           2'($urandom_range(0, 3)), 32'($signed(8'($urandom))),
           $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the multicycle CPU. It replaces the plain load-enable PC register.
- Computes the next PC internally from a source select: sequential, branch-relative, absolute jump or return.
- Qualifies updates with unconditional and conditional write enables, matching the control FSM's PCWrite / PCWriteCond.
- Holds a small circular return-address stack (RAS) for call/return, with sticky overflow and underflow status for the debug/exception logic.

Parameters:
WIDTH, 32, PC and address width in bits
RESET_VECTOR, 0, PC value loaded by reset; also the fallback return target on an empty-stack return
INCR, 4, sequential increment in bytes
ALIGN_SHIFT, 2, instruction alignment; branch offsets are shifted left by this amount, and absolute targets have this many low bits forced to 0
RAS_DEPTH, 4, return-stack entries; power of two, at least 2

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  synchronous reset, active-high
pc_write  in  1  unconditional PC update
pc_write_cond  in  1  conditional PC update, taken only when cond_true=1
cond_true  in  1  branch condition (ALU zero or similar)
src_sel  in  2  0=seq, 1=branch, 2=jump, 3=return
branch_off  in  WIDTH  signed word offset
jump_target  in  WIDTH  absolute target
push  in  1  call: push the return address
pop  in  1  return: pop the stack
pc  out  WIDTH  current PC (registered)
ras_top  out  WIDTH  top-of-stack value; RESET_VECTOR when the stack is empty
ras_empty  out  1  stack count = 0
ras_full  out  1  stack count = RAS_DEPTH
ras_overflow  out  1  sticky; set when push occurs with the stack full
ras_underflow  out  1  sticky; set when pop occurs with the stack empty
misalign  out  1  one-cycle pulse when a jump target had non-zero low bits

Behaviour:
- Reset (rst=1 at a clock edge, overrides everything):
  - pc=RESET_VECTOR, stack count=0, top pointer=0.
  - ras_overflow, ras_underflow and misalign all 0.
  - Stack entry contents are don't-care.
- upd = pc_write | (pc_write_cond & cond_true). When upd=0: pc holds, push/pop are ignored, misalign=0.
- Next PC when upd=1 (all arithmetic modulo 2^WIDTH, wraps silently):
  - seq: pc+INCR.
  - branch: pc+INCR+(sign-extended branch_off << ALIGN_SHIFT).
  - jump: jump_target with bits [ALIGN_SHIFT-1:0] cleared. misalign=1 for the following cycle if any cleared bit was 1.
  - return: ras_top as seen before this edge's pop. If the stack is empty, RESET_VECTOR.
- Latency: pc changes on the same edge that samples upd. There is no combinational path from inputs to pc.
- Stack actions, only when upd=1:
  - push only: write pc+INCR (the pre-update pc) at top+1; top++, count++.
    - If full: overwrite the oldest entry (circular), count stays at RAS_DEPTH, set ras_overflow.
  - pop only:
    - If count>0: top--, count--.
    - If empty: no pointer change, set ras_underflow.
  - push and pop together: replace the top entry with pc+INCR; pointer and count are unchanged.
    - If empty: behave as push, and also set ras_underflow.
- push or pop is legal with any src_sel. Typical pairings: push with jump (call), pop with return.
- Sticky flags clear only on rst.
- ras_top, ras_empty and ras_full are combinational from registered stack state.
- Reset asserted mid-sequence discards all stack contents; the next cycle starts clean.

Decomposition:
- Shared package cpu_pkg:
  - src_sel encodings: PC_SRC_SEQ=0, PC_SRC_BR=1, PC_SRC_JMP=2, PC_SRC_RET=3.
  - Default WIDTH and RESET_VECTOR constants.
- One sub-module, ras_stack: parametrised circular stack holding the storage array, top pointer and count, with push/pop/replace logic.
- pc_unit keeps the next-PC mux, the update qualifier and the flag registers.

Test Plan:
- Reset then pc_write=1, src_sel=0 for 3 cycles -> pc = 0x0, 0x4, 0x8, 0xC. Then pc_write=0 -> pc holds at 0xC.
- pc=0x10; pc_write_cond=1, src_sel=1, branch_off=-2:
  - cond_true=0 -> pc stays 0x10.
  - cond_true=1 -> pc = 0x14-8 = 0x0C.
- pc=0x20; jump to 0x103 with push=1 -> pc=0x100, misalign=1 for one cycle, ras_top=0x24. Then src_sel=3, pop=1 -> pc=0x24, ras_empty=1.
- With RAS_DEPTH=4, five calls from pc=0x0,0x40,0x80,0xC0,0x100 -> ras_overflow=1, ras_full=1. Then four returns yield 0x104, 0xC4, 0x84, 0x44; the fifth pop sets ras_underflow and pc=RESET_VECTOR.
- WIDTH=8 instance with pc=0xFC and seq update -> pc wraps to 0x00, no flags set.
- rst asserted during a stack holding 2 entries, in the same cycle as a push -> next cycle pc=RESET_VECTOR, ras_empty=1, all flags 0.
